axil_reg_slave: RTL
===================

AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, meaning byte-address width (4 registers x 4 bytes).
REQ-003 SHALL have port S_AXI_ACLK, input, 1 bit: the single clock.
REQ-004 SHALL have port S_AXI_ARESETN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have the write address ports: S_AXI_AWADDR in ADDR_WIDTH, S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1.
REQ-006 SHALL have the write data ports: S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1.
REQ-007 SHALL have the write response ports: S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-008 SHALL have the read address ports: S_AXI_ARADDR in ADDR_WIDTH, S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1.
REQ-009 SHALL have the read data ports: S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.

Function
REQ-010 SHALL implement four 32-bit read/write registers, reg0..reg3, selected by address bits [3:2]; address bits [1:0] and the PROT inputs are ignored.
REQ-011 Write FSM states SHALL be: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
REQ-012 In W_IDLE, AWREADY and WREADY SHALL both be 1; AW and W SHALL be accepted in either order or in the same cycle.
REQ-013 After an AW-only handshake the FSM SHALL go to W_HAVE_ADDR (AWREADY=0, WREADY=1), latching the address; after a W-only handshake it SHALL go to W_HAVE_DATA (WREADY=0, AWREADY=1), latching data and strobe.
REQ-014 When both address and data are held, the register SHALL update on that clock edge, byte lanes gated by WSTRB (WSTRB=0 leaves the register unchanged but still gives a response), and the FSM SHALL enter W_RESP with BVALID=1 on the next cycle.
REQ-015 In W_RESP, AWREADY=WREADY=0; BVALID SHALL hold until BREADY is sampled high, then return to W_IDLE; at most one outstanding write.
REQ-016 Read FSM states SHALL be R_IDLE (ARREADY=1) and R_DATA (RVALID=1, ARREADY=0).
REQ-017 On the ARVALID&ARREADY handshake, RDATA SHALL be registered from the addressed register, RVALID=1 on the next cycle; RDATA/RVALID SHALL hold stable until RREADY, then return to R_IDLE.
REQ-018 BRESP and RRESP SHALL always be OKAY (2'b00); all four addresses are decoded.
REQ-019 Read and write channels SHALL operate independently; a same-cycle read and write to the same register SHALL return the pre-write value.
REQ-020 Minimum latency SHALL be: AW+W handshake to BVALID, 1 cycle; AR handshake to RVALID, 1 cycle.
REQ-021 Back-to-back throughput SHALL be one write per 2 cycles and one read per 2 cycles when BREADY/RREADY are held high.

Reset
REQ-022 On S_AXI_ARESETN=0, asynchronously: both FSMs go to IDLE, reg0..reg3 = 0, BVALID=RVALID=0, RDATA=0, BRESP=RRESP=0.
REQ-023 During reset AWREADY, WREADY and ARREADY SHALL be 0; they SHALL assert on the first edge after deassertion.
REQ-024 Reset mid-transaction SHALL discard the latched address and data, with no register update and no response issued.

Structure
REQ-025 Package axil_reg_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants, NUM_REGS=4, ADDR_LSB=2, and the write/read FSM state enums.
REQ-026 The AW/W capture plus write FSM SHALL be a sub-module, axil_wr_capture; the register array, read path and top-level wiring SHALL be in axil_reg_slave.

Verification
REQ-027 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read all four -> reads return 0x1..0x4, all responses OKAY.
REQ-028 W presented 3 cycles before AW (data 0xDEADBEEF, addr 0x4) -> single BVALID after AW; reg1 = 0xDEADBEEF.
REQ-029 reg2=0xFFFFFFFF, write 0x12345678 with WSTRB=4'b0101 -> reg2 reads 0xFF34FF78.
REQ-030 BREADY/RREADY held low 10 cycles -> BVALID, RVALID and RDATA stay stable, and no new AW/AR is accepted.
REQ-031 Simultaneous write 0xA5A5A5A5 and read at 0x8 (old value 0x3) -> RDATA=0x3; a subsequent read returns 0xA5A5A5A5.
REQ-032 Assert reset while in W_HAVE_ADDR -> no BVALID; all registers read 0 afterwards; next write completes normally.

Source files
------------

// File: rtl/axil_reg_pkg.sv
// Shared constants, FSM state types and address helper for the AXI4-Lite register slave.
package axil_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned ADDR_LSB = 2;
  localparam int unsigned IDX_W    = 2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Byte address to register index; bits [1:0] are ignored.
  function automatic logic [IDX_W-1:0] reg_index(input logic [3:0] addr);
    return addr[ADDR_LSB +: IDX_W];
  endfunction

endpackage

// File: rtl/axil_wr_capture.sv
// AW/W capture and write-response FSM. Accepts address and data in either order and
// emits a single-cycle register write strobe once both are held.
module axil_wr_capture
  import axil_reg_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [3:0]           awaddr_i,
  input  logic                 awvalid_i,
  output logic                 awready_o,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [StrbWidth-1:0] wstrb_i,
  input  logic                 wvalid_i,
  output logic                 wready_o,
  output logic                 bvalid_o,
  input  logic                 bready_i,
  output logic                 wr_en_o,
  output logic [IDX_W-1:0]     wr_idx_o,
  output logic [DataWidth-1:0] wr_data_o,
  output logic [StrbWidth-1:0] wr_strb_o
);

  wr_state_e            state_q, state_d;
  logic                 live_q;
  logic [IDX_W-1:0]     addr_q;
  logic [DataWidth-1:0] data_q;
  logic [StrbWidth-1:0] strb_q;
  logic                 aw_fire, w_fire, have_addr, have_data;

  // Readies stay low during reset and rise on the first edge after release.
  assign awready_o = live_q & ((state_q == W_IDLE) | (state_q == W_HAVE_DATA));
  assign wready_o  = live_q & ((state_q == W_IDLE) | (state_q == W_HAVE_ADDR));
  assign bvalid_o  = (state_q == W_RESP);

  assign aw_fire   = awvalid_i & awready_o;
  assign w_fire    = wvalid_i & wready_o;
  assign have_addr = aw_fire | (state_q == W_HAVE_ADDR);
  assign have_data = w_fire | (state_q == W_HAVE_DATA);

  assign wr_en_o   = have_addr & have_data;
  assign wr_idx_o  = aw_fire ? reg_index(awaddr_i) : addr_q;
  assign wr_data_o = w_fire ? wdata_i : data_q;
  assign wr_strb_o = w_fire ? wstrb_i : strb_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      W_IDLE: begin
        if (aw_fire && w_fire) begin
          state_d = W_RESP;
        end else if (aw_fire) begin
          state_d = W_HAVE_ADDR;
        end else if (w_fire) begin
          state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: if (w_fire)   state_d = W_RESP;
      W_HAVE_DATA: if (aw_fire)  state_d = W_RESP;
      W_RESP:      if (bready_i) state_d = W_IDLE;
      default:                   state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= W_IDLE;
      live_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (aw_fire) addr_q <= reg_index(awaddr_i);
      if (w_fire) begin
        data_q <= wdata_i;
        strb_q <= wstrb_i;
      end
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing four 32-bit read/write registers with independent
// read and write channels.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int unsigned StrbW = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                          wr_en;
  logic [IDX_W-1:0]              wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [StrbW-1:0]              wr_strb;

  rd_state_e                     rd_state_q, rd_state_d;
  logic                          rd_live_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic                          ar_fire;

  // PROT and the sub-word address bits carry no meaning for this block.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  axil_wr_capture #(
    .DataWidth (C_S_AXI_DATA_WIDTH),
    .StrbWidth (StrbW)
  ) u_wr_capture (
    .clk_i     (S_AXI_ACLK),
    .rst_ni    (S_AXI_ARESETN),
    .awaddr_i  (S_AXI_AWADDR[3:0]),
    .awvalid_i (S_AXI_AWVALID),
    .awready_o (S_AXI_AWREADY),
    .wdata_i   (S_AXI_WDATA),
    .wstrb_i   (S_AXI_WSTRB),
    .wvalid_i  (S_AXI_WVALID),
    .wready_o  (S_AXI_WREADY),
    .bvalid_o  (S_AXI_BVALID),
    .bready_i  (S_AXI_BREADY),
    .wr_en_o   (wr_en),
    .wr_idx_o  (wr_idx),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb)
  );

  assign S_AXI_BRESP = RESP_OKAY;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < StrbW; b++) begin
        if (wr_strb[b]) regs_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign S_AXI_ARREADY = rd_live_q & (rd_state_q == R_IDLE);
  assign S_AXI_RVALID  = (rd_state_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign ar_fire       = S_AXI_ARVALID & S_AXI_ARREADY;

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      R_IDLE:  if (ar_fire)      rd_state_d = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rd_state_d = R_IDLE;
      default:                   rd_state_d = R_IDLE;
    endcase
  end

  // rdata_q samples regs_q before any same-edge write lands, giving the old value.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_q <= R_IDLE;
      rd_live_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_live_q  <= 1'b1;
      if (ar_fire) rdata_q <= regs_q[reg_index(S_AXI_ARADDR[3:0])];
    end
  end

endmodule
